// File: rtl/memory_arbiter.sv
// Purpose: shares one memory port between instruction fetch (IF) and load/store (D), with round-robin on ties.
// Latency: a read completes with done in cycle L+1 after the request is seen in IDLE; a store completes in cycle 2.
// Backpressure: requests hold req until done; req is sampled only in IDLE, so waiting requests are never dropped.
module memory_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic        owner_q, owner_d;     // 1 = D; doubles as last_grant for round-robin
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_d;

  // Next-state logic: arbitration in IDLE, latency counting in ACCESS, single RESP cycle.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    // On a tie, D wins only if IF was the last owner.
    pick_d     = d_req && (!if_req || !owner_q);

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          owner_d   = pick_d;
          we_d      = pick_d && d_we;
          addr_d    = pick_d ? d_addr : if_addr;
          wdata_d   = pick_d ? d_wdata : 32'h0;
          wstrb_d   = (pick_d && d_we) ? d_wstrb : 4'h0;
          lat_cnt_d = 4'd1;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          lat_cnt_d = 4'd0;
          state_d   = S_RESP;
        end else if (lat_cnt_q == LAT) begin
          if (owner_q) d_rdata_d  = mem_rdata;
          else         if_rdata_d = mem_rdata;
          lat_cnt_d = 4'd0;
          state_d   = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latch registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= 4'd0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory-side outputs decode from registered state only, so they drop as soon as reset hits.
  always_comb begin
    mem_re    = (state_q == S_ACCESS) && !we_q;
    mem_we    = (state_q == S_ACCESS) && we_q;
    mem_addr  = (state_q == S_ACCESS) ? addr_q  : 32'h0;
    mem_wdata = (state_q == S_ACCESS) ? wdata_q : 32'h0;
    mem_wstrb = (state_q == S_ACCESS) ? wstrb_q : 4'h0;
    if_done   = (state_q == S_RESP) && !owner_q;
    d_done    = (state_q == S_RESP) && owner_q;
    busy      = (state_q != S_IDLE);
    grant_d   = owner_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule
